// File: rtl/ternary_pkg.sv
// Shared types and constants for the ternary matrix-vector multiply core:
// FSM state encoding, command opcodes, 2-bit weight codes and weight decode.
package ternary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MULT,
        ST_OUT
    } state_t;

    // Command opcodes carried in in_data[15:12] while idle
    localparam logic [3:0] CMD_LOAD = 4'hA;
    localparam logic [3:0] CMD_MULT = 4'h5;

    // 2-bit weight codes; the reserved code behaves as zero
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_RSV  = 2'b10;
    localparam logic [1:0] W_NEG  = 2'b11;

    // Activation width inside a 16-bit beat (two activations per beat)
    localparam int ACT_W  = 8;
    localparam int BEAT_W = 16;

    // Map a 2-bit weight code onto {-1, 0, +1}
    function automatic logic signed [1:0] ternary_decode(input logic [1:0] code);
        case (code)
            W_POS:   return 2'sb01;
            W_NEG:   return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/ternary_mac_lane.sv
// One output row of the ternary MVM: a signed accumulator updated by the
// sum of two ternary-weighted activations per beat.
module ternary_mac_lane
    import ternary_pkg::*;
#(
    parameter int ACC_W = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic [3:0]              w_pair,
    input  logic [BEAT_W-1:0]       x_pair,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] acc_next
);

    // Sign-extend an activation and apply a ternary weight (no multiplier needed)
    function automatic logic signed [ACC_W-1:0] term(input logic [1:0] code,
                                                      input logic [ACT_W-1:0] x);
        logic signed [ACC_W-1:0] xe;
        xe = {{(ACC_W-ACT_W){x[ACT_W-1]}}, x};
        case (ternary_decode(code))
            2'sb01:  return xe;
            2'sb11:  return -xe;
            default: return '0;
        endcase
    endfunction

    // Bits [1:0] weight the upper activation byte (even index), [3:2] the lower byte
    assign acc_next = acc + term(w_pair[1:0], x_pair[15:8]) + term(w_pair[3:2], x_pair[7:0]);

    // Accumulate on each accepted beat; clear dominates enable
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/ternary_mvm_core.sv
// Ternary matrix-vector multiply core: loads a 2-bit-coded weight matrix,
// streams activation pairs through OUT_LEN parallel MAC lanes, then emits
// the result vector one element per cycle.
// Optional build macro TERNARY_MVM_SAT_EN: results saturate to the signed
// BIT_WIDTH range; otherwise the low BIT_WIDTH accumulator bits are emitted.
module ternary_mvm_core
    import ternary_pkg::*;
#(
    parameter int IN_LEN    = 16,
    parameter int OUT_LEN   = 8,
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          in_data,
    input  logic                 in_valid,
    input  logic                 abort,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 weights_ok
);

    localparam int LOAD_BEATS = IN_LEN * OUT_LEN / 8;
    localparam int MULT_BEATS = IN_LEN / 2;
    localparam int MAX_BEATS  = (LOAD_BEATS > MULT_BEATS) ? LOAD_BEATS : MULT_BEATS;
    localparam int CNT_W      = $clog2(MAX_BEATS + 1);
    localparam int OI_W       = $clog2(OUT_LEN + 1);
    localparam int ACC_W      = BIT_WIDTH + $clog2(IN_LEN) + 1;
    localparam int W_BITS     = 2 * IN_LEN * OUT_LEN;

    state_t                  state;
    logic [CNT_W-1:0]        beat_cnt;
    logic [OI_W-1:0]         out_idx;
    logic [W_BITS-1:0]       weights;
    logic signed [ACC_W-1:0] acc      [OUT_LEN];
    logic signed [ACC_W-1:0] acc_next [OUT_LEN];
    logic signed [ACC_W-1:0] sel_acc;
    logic signed [ACC_W-1:0] sel_next;
    logic                    mult_start;
    logic                    lane_clear;
    logic                    lane_en;

    // Convert a full-width accumulator into an output element
    function automatic logic [BIT_WIDTH-1:0] to_result(input logic signed [ACC_W-1:0] a);
`ifdef TERNARY_MVM_SAT_EN
        logic signed [ACC_W-1:0] res_max;
        logic signed [ACC_W-1:0] res_min;
        res_max = {{(ACC_W-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
        res_min = ~res_max;
        if (a > res_max)      return res_max[BIT_WIDTH-1:0];
        else if (a < res_min) return res_min[BIT_WIDTH-1:0];
        else                  return a[BIT_WIDTH-1:0];
`else
        return a[BIT_WIDTH-1:0];
`endif
    endfunction

    assign busy       = (state != ST_IDLE);
    assign mult_start = (state == ST_IDLE) && in_valid && (in_data[15:12] == CMD_MULT) && weights_ok;
    assign lane_clear = mult_start || abort;
    assign lane_en    = (state == ST_MULT) && in_valid;

    // Select the accumulator (and its next value) addressed by the output index
    always_comb begin
        // NOTE: combinational outputs get a default first so no path can infer a latch.
        sel_acc  = '0;
        sel_next = '0;
        for (int k = 0; k < OUT_LEN; k++) begin
            if (out_idx == OI_W'(k)) begin
                sel_acc  = acc[k];
                sel_next = acc_next[k];
            end
        end
    end

    for (genvar o = 0; o < OUT_LEN; o++) begin : g_lane
        logic [3:0] w_pair;

        // Pick this row's two weights that pair with the current activation beat
        always_comb begin
            w_pair = '0;
            for (int j = 0; j < MULT_BEATS; j++) begin
                if (beat_cnt == CNT_W'(j)) begin
                    w_pair = weights[2*(o*IN_LEN + 2*j) +: 4];
                end
            end
        end

        ternary_mac_lane #(
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (lane_clear),
            .en       (lane_en),
            .w_pair   (w_pair),
            .x_pair   (in_data),
            .acc      (acc[o]),
            .acc_next (acc_next[o])
        );
    end

    // Control FSM, weight store, beat/output counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the weight store is plain flops and must reset, since a stale matrix would be visible after reset.
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            out_idx    <= '0;
            weights    <= '0;
            weights_ok <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (abort) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_data[15:12] == CMD_LOAD) begin
                        state      <= ST_LOAD;
                        weights_ok <= 1'b0;
                        beat_cnt   <= '0;
                    end else if (mult_start) begin
                        state    <= ST_MULT;
                        beat_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        for (int k = 0; k < LOAD_BEATS; k++) begin
                            if (beat_cnt == CNT_W'(k)) begin
                                weights[BEAT_W*k +: BEAT_W] <= in_data;
                            end
                        end
                        if (beat_cnt == CNT_W'(LOAD_BEATS - 1)) begin
                            state      <= ST_IDLE;
                            weights_ok <= 1'b1;
                            beat_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_MULT: begin
                    if (in_valid) begin
                        if (beat_cnt == CNT_W'(MULT_BEATS - 1)) begin
                            // out_idx is 0 here, so sel_next is y[0] including this beat
                            state     <= ST_OUT;
                            beat_cnt  <= '0;
                            out_valid <= 1'b1;
                            out_data  <= to_result(sel_next);
                            out_idx   <= OI_W'(1);
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_idx == OI_W'(OUT_LEN)) begin
                        state     <= ST_IDLE;
                        out_idx   <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end else begin
                        out_data <= to_result(sel_acc);
                        out_idx  <= out_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_mvm_core.sv
// Directed self-checking bench for ternary_mvm_core (IN_LEN=16, OUT_LEN=8,
// BIT_WIDTH=8). Expected values are hand-computed; the saturating build is
// selected with TERNARY_MVM_SAT_EN.
module tb_ternary_mvm_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [15:0] in_data;
    logic       in_valid;
    logic       abort;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       weights_ok;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ternary_mvm_core #(
        .IN_LEN    (16),
        .OUT_LEN   (8),
        .BIT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .abort      (abort),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .weights_ok (weights_ok)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    // Beats 0 and 1 carry row 0; beats 2..15 carry rows 1..7
    task automatic load_weights(input logic [15:0] first2, input logic [15:0] rest);
        send(16'hA000);
        for (int k = 0; k < 16; k++) send((k < 2) ? first2 : rest);
        @(negedge clk);
        check("weights_ok after load", {15'd0, weights_ok}, 16'd1);
        check("busy after load", {15'd0, busy}, 16'd0);
    endtask

    task automatic mult_run(input string name, input logic [15:0] xbeat, input bit gaps,
                            input bit noise, input logic [7:0] exp0, input logic [7:0] exp_rest);
        send(16'h5000);
        for (int j = 0; j < 8; j++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
            if (j == 4) begin
                @(negedge clk);
                check({name, " busy mid"}, {15'd0, busy}, 16'd1);
                check({name, " no early valid"}, {15'd0, out_valid}, 16'd0);
            end
            send(xbeat);
        end
        if (noise) begin
            in_valid = 1'b1;
            in_data  = 16'hA000;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("%s y%0d valid", name, k), {15'd0, out_valid}, 16'd1);
            check($sformatf("%s y%0d data", name, k), {8'd0, out_data}, {8'd0, (k == 0) ? exp0 : exp_rest});
        end
        @(negedge clk);
        check({name, " valid drops"}, {15'd0, out_valid}, 16'd0);
        check({name, " data zero"}, {8'd0, out_data}, 16'd0);
        check({name, " idle after out"}, {15'd0, busy}, 16'd0);
        if (noise) check({name, " out ignores cmd"}, {15'd0, weights_ok}, 16'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        in_data  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset out_valid", {15'd0, out_valid}, 16'd0);
        check("reset out_data", {8'd0, out_data}, 16'd0);
        check("reset busy", {15'd0, busy}, 16'd0);
        check("reset weights_ok", {15'd0, weights_ok}, 16'd0);

        // Multiply command with no weights is ignored
        send(16'h5000);
        repeat (3) begin
            @(negedge clk);
            check("mult w/o weights busy", {15'd0, busy}, 16'd0);
            check("mult w/o weights valid", {15'd0, out_valid}, 16'd0);
        end

        // All +1 weights, all x=1: every y = 16
        load_weights(16'h5555, 16'h5555);
        mult_run("ones", 16'h0101, 1'b0, 1'b0, 8'd16, 8'd16);

        // Even weights +1, odd -1; x even=3, odd=-2: each pair 5, y = 40
        load_weights(16'hDDDD, 16'hDDDD);
        mult_run("alt", 16'h03FE, 1'b0, 1'b0, 8'd40, 8'd40);
        mult_run("alt_gaps", 16'h03FE, 1'b1, 1'b1, 8'd40, 8'd40);

        // Row 0 all -1, x=100: y0 = -1600
`ifdef TERNARY_MVM_SAT_EN
        load_weights(16'hFFFF, 16'h0000);
        mult_run("row0_neg", 16'h6464, 1'b0, 1'b0, 8'h80, 8'h00);
`else
        load_weights(16'hFFFF, 16'h0000);
        mult_run("row0_neg", 16'h6464, 1'b0, 1'b0, 8'hC0, 8'h00);
`endif

        // All -1, x=-128: y = +2048 (max accumulator magnitude)
`ifdef TERNARY_MVM_SAT_EN
        load_weights(16'hFFFF, 16'hFFFF);
        mult_run("max_pos", 16'h8080, 1'b0, 1'b0, 8'h7F, 8'h7F);
`else
        load_weights(16'hFFFF, 16'hFFFF);
        mult_run("max_pos", 16'h8080, 1'b0, 1'b0, 8'h00, 8'h00);
`endif

        // Reserved code behaves as zero
        load_weights(16'hAAAA, 16'hAAAA);
        mult_run("reserved", 16'h3232, 1'b0, 1'b0, 8'h00, 8'h00);

        // Abort wins over a simultaneous load command
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hA000;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort vs cmd busy", {15'd0, busy}, 16'd0);
        check("abort vs cmd weights_ok", {15'd0, weights_ok}, 16'd1);

        // Abort wins over the final multiply beat; accumulators restart cleanly
        load_weights(16'h5555, 16'h5555);
        send(16'h5000);
        repeat (7) send(16'h0101);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0101;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort last beat busy", {15'd0, busy}, 16'd0);
            check("abort last beat valid", {15'd0, out_valid}, 16'd0);
        end
        mult_run("after_abort", 16'h0101, 1'b0, 1'b0, 8'd16, 8'd16);

        // Abort after 5 of 16 load beats
        send(16'hA000);
        repeat (5) send(16'h5555);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort load busy", {15'd0, busy}, 16'd0);
        check("abort load weights_ok", {15'd0, weights_ok}, 16'd0);
        send(16'h5000);
        repeat (3) begin
            @(negedge clk);
            check("mult after abort busy", {15'd0, busy}, 16'd0);
            check("mult after abort valid", {15'd0, out_valid}, 16'd0);
        end

        // Reset mid-multiply discards everything
        load_weights(16'h5555, 16'h5555);
        send(16'h5000);
        repeat (3) send(16'h0101);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid reset busy", {15'd0, busy}, 16'd0);
        check("mid reset weights_ok", {15'd0, weights_ok}, 16'd0);
        check("mid reset valid", {15'd0, out_valid}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ternary_mvm_core.md
TERNARY_MVM_CORE -- requirements
Module: ternary_mvm_core

Interface
REQ-001 Parameter IN_LEN, default 16: activations per input vector; must be even.
REQ-002 Parameter OUT_LEN, default 8: outputs per result vector; IN_LEN*OUT_LEN must be a multiple of 8.
REQ-003 Parameter BIT_WIDTH, default 8: signed activation and result width.
REQ-004 clk  in  1  sole clock; all logic updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_data  in  16  command, weight beat or activation beat.
REQ-007 in_valid  in  1  in_data is valid this cycle.
REQ-008 abort  in  1  return to IDLE from any state.
REQ-009 out_data  out  BIT_WIDTH  signed result element.
REQ-010 out_valid  out  1  out_data holds a result this cycle.
REQ-011 busy  out  1  high in LOAD, MULT and OUT.
REQ-012 weights_ok  out  1  a complete weight matrix is stored.

Function
REQ-013 The block SHALL implement states IDLE, LOAD, MULT and OUT.
REQ-014 In IDLE, in_valid with in_data[15:12]=4'hA SHALL enter LOAD and clear weights_ok.
REQ-015 In IDLE, in_valid with in_data[15:12]=4'h5 SHALL enter MULT only if weights_ok=1; otherwise the command is ignored.
REQ-016 All other IDLE inputs SHALL be ignored.
REQ-017 LOAD SHALL accept IN_LEN*OUT_LEN/8 beats; beat k carries weights for flat indices 8k..8k+7 (flat = o*IN_LEN+i), with bits [1:0] holding the lowest index.
REQ-018 Weight encoding SHALL be: 2'b00=0, 2'b01=+1, 2'b11=-1; reserved 2'b10 SHALL be treated as 0.
REQ-019 On acceptance of the last LOAD beat, the block SHALL return to IDLE and set weights_ok the next cycle.
REQ-020 On MULT entry, all accumulators SHALL be cleared.
REQ-021 MULT SHALL accept IN_LEN/2 beats; beat j carries x[2j]=in_data[15:8] and x[2j+1]=in_data[7:0], both signed.
REQ-022 Each beat SHALL update all OUT_LEN accumulators in parallel by W[o][2j]*x[2j] + W[o][2j+1]*x[2j+1].
REQ-023 Accumulator width SHALL be BIT_WIDTH+$clog2(IN_LEN)+1 signed, so overflow cannot occur.
REQ-024 If in_valid=0 during LOAD or MULT, the beat counter SHALL hold.
REQ-025 The cycle after the last MULT beat, the block SHALL be in OUT with out_valid=1 and out_data=y[0].
REQ-026 OUT SHALL emit y[1]..y[OUT_LEN-1] on consecutive cycles, ignore in_valid, then return to IDLE with out_valid=0.
REQ-027 When out_valid=0, out_data SHALL be 0.
REQ-028 abort SHALL force IDLE the next cycle, with out_valid=0 and accumulators cleared.
REQ-029 abort during LOAD SHALL leave weights_ok=0.
REQ-030 abort SHALL take priority over a simultaneous final beat or command.

Reset
REQ-031 rst SHALL set state=IDLE, all weights=0, accumulators=0, counters=0, weights_ok=0, busy=0, out_valid=0 and out_data=0 on the next edge.
REQ-032 rst asserted mid-operation SHALL discard all progress.

Configuration
REQ-033 With TERNARY_MVM_SAT_EN defined, each result SHALL saturate to the signed BIT_WIDTH range.
REQ-034 Without TERNARY_MVM_SAT_EN, each result SHALL be the low BIT_WIDTH bits of the accumulator (two's-complement wrap).

Structure
REQ-035 Package ternary_pkg SHALL hold the state enum, command opcodes 4'hA and 4'h5, weight-encoding constants and the ternary-decode function.
REQ-036 Sub-module ternary_mac_lane SHALL implement one output's accumulator and the 2-term ternary update; the core SHALL instantiate it OUT_LEN times.

Verification (IN_LEN=16, OUT_LEN=8, BIT_WIDTH=8)
REQ-037 Load all weights 2'b01, then MULT with all x=1 -> eight consecutive out_valid cycles, each out_data=16.
REQ-038 Row 0 all 2'b11, other weights 0, all x=100 -> y[0]=-128 with TERNARY_MVM_SAT_EN and -64 (0xC0) without; y[1..7]=0.
REQ-039 Command 4'h5 after reset, before any LOAD -> busy stays 0, no out_valid.
REQ-040 abort after 5 of 16 LOAD beats -> IDLE next cycle, weights_ok=0, and a following 4'h5 command is ignored.
REQ-041 MULT with random in_valid gaps -> results identical to the gap-free run, with the first out_valid one cycle after the last beat.
REQ-042 All weights 2'b10, all x=50 -> all outputs 0.
